// File: rtl/rpn_stack_ctrl.sv
// RPN token controller driving an external push/pop stack; tracks depth and a sticky first error.
// Optional RPN_SAT_ARITH_EN: ADD saturates at 8'hFF and SUB floors at 8'h00 instead of wrapping.
module rpn_stack_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [7:0]       tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [7:0]       stk_data_in,
  input  logic [7:0]       stk_data_out,
  output logic [7:0]       result,
  output logic             result_valid,
  output logic [CNT_W-1:0] depth,
  output logic             error,
  output logic [1:0]       error_code
);

  typedef enum logic [3:0] {
    IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, WB, POP_O, CAP_O
  } state_t;

  localparam logic [1:0] E_UNDER = 2'b01, E_OVER = 2'b10, E_ILL = 2'b11;

  state_t     state, state_nx;
  logic [2:0] op;
  logic [7:0] b_reg;
  logic [7:0] data;
  logic       accept;
  logic       err_set;
  logic [1:0] err_val;

  function automatic logic [7:0] alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, a} + {1'b0, b};
    res = 8'h00;
    case (f)
`ifdef RPN_SAT_ARITH_EN
      3'b000:  res = sum[8] ? 8'hFF : sum[7:0];
      3'b001:  res = (b > a) ? 8'h00 : a - b;
`else
      3'b000:  res = sum[7:0];
      3'b001:  res = a - b;
`endif
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = a ^ b;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  assign accept      = tok_valid && tok_ready;
  assign tok_ready   = (state == IDLE);
  assign stk_push    = (state == PUSH) || (state == WB);
  assign stk_pop     = (state == POP_B) || (state == POP_A) || (state == POP_O);
  assign stk_data_in = data;

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_val  = 2'b00;
    case (state)
      IDLE: if (accept) begin
        if (!tok_is_op) begin
          if (depth == CNT_W'(DEPTH)) begin
            err_set = 1'b1;
            err_val = E_OVER;
          end else state_nx = PUSH;
        end else begin
          case (tok_data[2:0])
            3'b101: if (depth == '0) begin
              err_set = 1'b1;
              err_val = E_UNDER;
            end else state_nx = POP_O;
            3'b110, 3'b111: begin
              err_set = 1'b1;
              err_val = E_ILL;
            end
            default: if (depth < CNT_W'(2)) begin
              err_set = 1'b1;
              err_val = E_UNDER;
            end else state_nx = POP_B;
          endcase
        end
      end
      PUSH:    state_nx = IDLE;
      POP_B:   state_nx = CAP_B;
      CAP_B:   state_nx = POP_A;
      POP_A:   state_nx = CAP_A;
      CAP_A:   state_nx = WB;
      WB:      state_nx = IDLE;
      POP_O:   state_nx = CAP_O;
      CAP_O:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op           <= 3'b000;
      b_reg        <= 8'h00;
      data         <= 8'h00;
      result       <= 8'h00;
      result_valid <= 1'b0;
      depth        <= '0;
      error        <= 1'b0;
      error_code   <= 2'b00;
    end else begin
      state        <= state_nx;
      result_valid <= 1'b0;
      if (state == IDLE && accept) op <= tok_data[2:0];
      if (state_nx == PUSH) data <= tok_data;
      // Only the first error is recorded; later ones are ignored but processing continues.
      if (err_set && !error) begin
        error      <= 1'b1;
        error_code <= err_val;
      end
      case (state)
        PUSH, WB:            depth <= depth + CNT_W'(1);
        POP_B, POP_A, POP_O: depth <= depth - CNT_W'(1);
        CAP_B:               b_reg <= stk_data_out;
        CAP_A:               data  <= alu(op, stk_data_out, b_reg);
        CAP_O: begin
          result       <= stk_data_out;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl: a queue-based RPN model predicts results, depth and errors.
module tb_rpn_stack_ctrl;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             tok_valid, tok_ready, tok_is_op;
  logic [7:0]       tok_data;
  logic             stk_push, stk_pop;
  logic [7:0]       stk_data_in, stk_data_out;
  logic [7:0]       result;
  logic             result_valid;
  logic [CNT_W-1:0] depth;
  logic             error;
  logic [1:0]       error_code;

  int checks = 0;
  int fails  = 0;

  rpn_stack_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out), .result(result),
    .result_valid(result_valid), .depth(depth), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  // Attached stack: registered pop data, valid the cycle after stk_pop.
  logic [7:0] mem[$];
  logic [7:0] pop_tmp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.delete();
      stk_data_out <= 8'h00;
    end else begin
      if (stk_push && mem.size() < DEPTH) mem.push_back(stk_data_in);
      if (stk_pop && mem.size() > 0) begin
        pop_tmp = mem.pop_back();
        stk_data_out <= pop_tmp;
      end
    end
  end

  // Reference model
  logic [7:0] mstk[$];
  logic [7:0] exp_q[$];
  logic [1:0] merr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input int f, input int a, input int b);
    int r;
    case (f)
`ifdef RPN_SAT_ARITH_EN
      0: r = (a + b > 255) ? 255 : a + b;
      1: r = (a < b) ? 0 : a - b;
`else
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
`endif
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic set_err(input logic [1:0] e);
    if (merr == 2'b00) merr = e;
  endtask

  task automatic model_token(input logic is_op, input logic [7:0] d);
    logic [7:0] a, b;
    if (!is_op) begin
      if (mstk.size() == DEPTH) set_err(2'b10);
      else mstk.push_back(d);
    end else begin
      case (d[2:0])
        3'd5: if (mstk.size() == 0) set_err(2'b01);
              else exp_q.push_back(mstk.pop_back());
        3'd6, 3'd7: set_err(2'b11);
        default: if (mstk.size() < 2) set_err(2'b01);
          else begin
            b = mstk.pop_back();
            a = mstk.pop_back();
            mstk.push_back(ref_alu(int'(d[2:0]), int'(a), int'(b)));
          end
      endcase
    end
  endtask

  // Waits (bounded) for IDLE at a negedge, then compares depth and error state against the model.
  task automatic check_idle();
    int n = 0;
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: tok_ready stuck at 0, expected 1");
    end
    check("depth", depth, mstk.size());
    check("error", error, merr != 2'b00);
    check("error_code", error_code, merr);
  endtask

  task automatic send(input logic is_op, input logic [7:0] d);
    @(negedge clk);
    check_idle();
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    @(posedge clk);
    model_token(is_op, d);
    #1 tok_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
    check_idle();
    check("results_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_tok_ready", tok_ready, 1);
    check("rst_stk_push", stk_push, 0);
    check("rst_stk_pop", stk_pop, 0);
    check("rst_stk_data_in", stk_data_in, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_depth", depth, 0);
    check("rst_error", error, 0);
    check("rst_error_code", error_code, 0);
  endtask

  task automatic do_reset(input bit verify);
    reset     = 1'b1;
    tok_valid = 1'b0;
    mstk.delete();
    exp_q.delete();
    merr = 2'b00;
    repeat (2) @(negedge clk);
    if (verify) check_reset_outputs();
    reset = 1'b0;
  endtask

  // Monitor: scoreboard pops on every result pulse; also guards stack protocol.
  always @(negedge clk) begin
    if (!reset) begin
      if (stk_push || stk_pop) check("push_pop_exclusive", stk_push && stk_pop, 0);
      if (stk_pop) check("pop_nonempty", mem.size() > 0, 1);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL result_unexpected: got 0x%0h, expected no result pulse", result);
        end else check("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = 8'h00;
    merr      = 2'b00;
    do_reset(1'b1);

    // Basic push/out and arithmetic cases
    send(0, 8'hA4); send(1, 8'h05);
    send(0, 8'h05); send(0, 8'h03); send(1, 8'h01); send(1, 8'h05);
    send(0, 8'h03); send(0, 8'h05); send(1, 8'h01); send(1, 8'h05);
    send(0, 8'hF0); send(0, 8'h20); send(1, 8'h00); send(1, 8'h05);
    send(0, 8'hC2); send(0, 8'h0F); send(1, 8'h04); send(1, 8'h05);
    send(0, 8'h3C); send(0, 8'h0F); send(1, 8'h02); send(1, 8'h05);
    send(0, 8'h30); send(0, 8'h05); send(1, 8'h03); send(1, 8'h05);
    settle();

    // Underflow: OUT on empty, ADD with one entry, processing continues
    do_reset(1'b0);
    send(1, 8'h05);
    send(0, 8'h09);
    send(1, 8'h00);
    send(1, 8'h05);
    settle();

    // Overflow followed by an illegal opcode keeps the first code
    do_reset(1'b0);
    for (int i = 0; i <= DEPTH; i++) send(0, 8'(i + 1));
    send(1, 8'h06);
    settle();

    // Reset during CAP_B of an ADD
    do_reset(1'b0);
    send(0, 8'h11); send(0, 8'h22); send(1, 8'h00);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    mstk.delete();
    exp_q.delete();
    merr = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    send(0, 8'h77); send(1, 8'h05);
    settle();

    // Randomized token streams
    for (int round = 0; round < 4; round++) begin
      do_reset(1'b0);
      for (int t = 0; t < 100; t++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 50) send(0, 8'($urandom_range(0, 255)));
        else if (r < 95) send(1, {5'($urandom_range(0, 31)), 3'($urandom_range(0, 5))});
        else send(1, {5'($urandom_range(0, 31)), 3'($urandom_range(6, 7))});
      end
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
Token-driven controller that sits directly upstream of the 8-bit stack block and drives its push/pop/data_in ports.
- Consumes a stream of reverse-Polish tokens (operands and opcodes) over a valid/ready handshake.
- Pushes operands, pops and combines the top two entries for ALU opcodes, and pushes the result.
- Pops the top entry to a result port on request.
- Tracks stack depth locally to flag overflow and underflow.

Parameters:
DEPTH, 16, stack capacity in entries; must match the attached stack.
CNT_W, 5, width of the local depth counter; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset; the same net also resets the stack.
tok_valid  input  1  token present.
tok_ready  output  1  controller can accept a token this cycle.
tok_is_op  input  1  1 = tok_data is an opcode, 0 = operand.
tok_data  input  8  operand value, or opcode in bits [2:0].
stk_push  output  1  push strobe to stack.
stk_pop  output  1  pop strobe to stack.
stk_data_in  output  8  value to push.
stk_data_out  input  8  stack popped data; valid the cycle after stk_pop.
result  output  8  last value popped by an OUT token.
result_valid  output  1  one-cycle pulse when result updates.
depth  output  CNT_W  current entry count.
error  output  1  sticky error flag.
error_code  output  2  00 none, 01 underflow, 10 overflow, 11 illegal opcode; holds the first error.

Behaviour:
- Reset: state IDLE. stk_push=0, stk_pop=0, stk_data_in=0, result=0, result_valid=0, depth=0, error=0, error_code=00, tok_ready=1.
- All outputs are registered or decoded from state only (Moore); no combinational path from tok_* to stk_*.
- Handshake: a token transfers when tok_valid && tok_ready. tok_ready=1 only in IDLE.
- Opcodes (tok_data[2:0]):
  - 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR.
  - b = first popped (top entry), a = second popped.
  - 101 OUT: pop the top entry to result.
  - 110, 111: illegal.
- FSM states: IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, WB, POP_O, CAP_O.
- IDLE, operand accepted:
  - depth==DEPTH: overflow error, token dropped, stay in IDLE.
  - Otherwise: latch the value and go to PUSH.
- PUSH: stk_push=1, stk_data_in=value, depth+1. Next state IDLE.
- IDLE, ALU opcode accepted:
  - depth<2: underflow error, token dropped, no stack access.
  - Otherwise: go to POP_B.
- POP_B: stk_pop=1, depth-1. Next CAP_B.
- CAP_B: latch b from stk_data_out. Next POP_A.
- POP_A: stk_pop=1, depth-1. Next CAP_A.
- CAP_A: latch a. Next WB.
- WB: stk_push=1, stk_data_in=f(a,b), depth+1. Next IDLE.
- IDLE, OUT accepted:
  - depth==0: underflow error.
  - Otherwise: POP_O (stk_pop=1, depth-1), then CAP_O (result<=stk_data_out, result_valid=1), then IDLE.
- Illegal opcode: error code 11, token dropped, stay in IDLE.
- Latency, accept edge to return to IDLE: operand 2 cycles, ALU op 6 cycles, OUT 3 cycles; tok_ready low throughout.
- Errors:
  - error is set on the first error and stays set until reset.
  - error_code records only the first error.
  - Processing continues after an error.
- Arithmetic: 8-bit unsigned, wraps modulo 256 (see optional feature).
- stk_push and stk_pop are never asserted in the same cycle.
- Reset mid-operation returns immediately to IDLE. Any partially popped operands are discarded; the stack is cleared by the shared reset.

Optional Feature:
RPN_SAT_ARITH_EN:
- Defined: ADD saturates at 8'hFF; SUB floors at 8'h00 when b>a.
- Undefined: ADD and SUB wrap modulo 256.
- Logic opcodes are unaffected either way.

Test Plan:
- Reset release, then operand 8'hA4 then OUT -> stk_push pulses with 8'hA4; result=8'hA4 with a single result_valid pulse; depth returns to 0.
- Operands 8'h05, 8'h03, SUB, OUT -> result=8'h02. Operands 8'h03, 8'h05, SUB, OUT -> result=8'hFE without the macro, 8'h00 with it.
- Operands 8'hF0, 8'h20, ADD, OUT -> 8'h10 wrapped, or 8'hFF with RPN_SAT_ARITH_EN; also C2 XOR 0F -> 8'hCD.
- Empty stack: OUT, then ADD with one entry present -> error=1, error_code=01; no stk_pop pulses; depth unchanged; later tokens still processed.
- DEPTH+1 operands -> the last one is dropped; error_code=10; depth==DEPTH; tok_data[2:0]=3'b110 afterwards leaves code at 10.
- Assert reset during CAP_B of an ADD -> all outputs return to reset values asynchronously; the next token is accepted normally after release.
